pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 101 ++++++++++
 tb/tb_pc_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction, holds it for decode,
// then advances the PC sequentially, to a jump target, or parks in HALT.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jb_taken,
  input  logic [15:0] jb_target,
  input  logic        stall,
  input  logic        halt,
  input  logic        resume,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        jbp_enable,
  output logic [15:0] inst,
  output logic        inst_valid,
  output logic        halted,
  output logic        misalign_err,
  output logic [15:0] retire_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]  r_state;
  logic [15:0] r_pc;
  logic [15:0] r_inst;
  logic [15:0] r_retire;
  logic        r_misalign;

  logic [15:0] w_pc_plus2;
  logic        w_exec_go;
  logic        w_take_jb;

  assign w_pc_plus2 = r_pc + 16'd2;
  // Stall outranks halt, halt outranks a taken jump.
  assign w_exec_go  = (r_state == S_EXEC) && !stall;
  assign w_take_jb  = w_exec_go && !halt && jb_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_inst     <= 16'h0000;
      r_retire   <= 16'h0000;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (imem_ack) begin
            r_inst  <= imem_rdata;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!stall) begin
            r_retire <= r_retire + 16'd1;
            if (halt) begin
              r_state <= S_HALT;
            end else begin
              r_state <= S_FETCH;
              if (jb_taken) begin
                r_pc <= {jb_target[15:1], 1'b0};
                if (jb_target[0]) r_misalign <= 1'b1;
              end else begin
                r_pc <= w_pc_plus2;
              end
            end
          end
        end
        S_HALT: begin
          if (resume) begin
            r_pc    <= w_pc_plus2;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req     = (r_state == S_FETCH);
  assign imem_addr    = r_pc;
  assign pc           = r_pc;
  assign pc_plus2     = w_pc_plus2;
  assign jbp_enable   = w_take_jb;
  assign inst         = r_inst;
  assign inst_valid   = (r_state == S_EXEC);
  assign halted       = (r_state == S_HALT);
  assign misalign_err = r_misalign;
  assign retire_cnt   = r_retire;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench for pc_sequencer: a driver plays memory and decoder,
// a monitor checks every fetch, every EXEC cycle and every resume.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        jb_taken;
  logic [15:0] jb_target;
  logic        stall;
  logic        halt;
  logic        resume;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        jbp_enable;
  logic [15:0] inst;
  logic        inst_valid;
  logic        halted;
  logic        misalign_err;
  logic [15:0] retire_cnt;

  localparam logic [15:0] RST_PC = 16'h0000;
  localparam int K_SEQ = 0, K_JMP = 1, K_HALT = 2;

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .jb_taken(jb_taken), .jb_target(jb_target),
    .stall(stall), .halt(halt), .resume(resume), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_req(imem_req), .imem_addr(imem_addr),
    .pc(pc), .pc_plus2(pc_plus2), .jbp_enable(jbp_enable), .inst(inst),
    .inst_valid(inst_valid), .halted(halted), .misalign_err(misalign_err),
    .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] inst;
    logic [15:0] pc;
    logic [15:0] ret;
    logic        jbp;
    logic        mis;
  } exec_t;

  logic [15:0] q_fetch[$];
  exec_t       q_exec[$];
  logic [15:0] q_halt[$];

  int n_pass = 0;
  int n_total = 0;
  bit mon_en = 1'b0;

  // reference state, advanced one retired instruction at a time
  logic [15:0] m_pc;
  logic [15:0] m_ret;
  logic        m_mis;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  task automatic no_exp(input string name);
    n_total++;
    $display("FAIL %s: actual=output presented required=none queued", name);
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (imem_req && imem_ack) begin
        if (q_fetch.size() == 0) no_exp("fetch");
        else begin
          logic [15:0] a;
          a = q_fetch.pop_front();
          chk("fetch_addr", imem_addr, a);
          chk("pc_plus2", pc_plus2, a + 16'd2);
        end
      end
      if (inst_valid) begin
        if (q_exec.size() == 0) no_exp("exec");
        else begin
          exec_t e;
          e = q_exec.pop_front();
          chk("exec_inst", inst, e.inst);
          chk("exec_pc", pc, e.pc);
          chk("exec_retire", retire_cnt, e.ret);
          chk("exec_jbp", {15'd0, jbp_enable}, {15'd0, e.jbp});
          chk("exec_misalign", {15'd0, misalign_err}, {15'd0, e.mis});
          chk("exec_req", {15'd0, imem_req}, 16'd0);
        end
      end
      if (halted) begin
        chk("halt_outs", {13'd0, imem_req, inst_valid, jbp_enable}, 16'd0);
        if (resume) begin
          if (q_halt.size() == 0) no_exp("resume");
          else chk("halt_pc", pc, q_halt.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise(input bit ack_ok);
    stall      = 1'($urandom);
    halt       = 1'($urandom);
    jb_taken   = 1'($urandom);
    jb_target  = 16'($urandom);
    resume     = 1'($urandom);
    imem_ack   = ack_ok ? 1'($urandom) : 1'b0;
    imem_rdata = 16'($urandom);
  endtask

  task automatic run_instr(input int kind, input logic [15:0] tgt, input int w,
                           input int s, input int r, input logic [15:0] rdata);
    int n;
    exec_t e;
    n = 0;
    while (!imem_req && n < 8) begin step(); n++; end
    if (!imem_req) no_exp("fetch_timeout");
    repeat (w) begin noise(1'b0); step(); end
    noise(1'b0);
    imem_ack = 1'b1;
    imem_rdata = rdata;
    q_fetch.push_back(m_pc);
    step();
    repeat (s) begin
      noise(1'b1);
      stall = 1'b1;
      e = '{inst: rdata, pc: m_pc, ret: m_ret, jbp: 1'b0, mis: m_mis};
      q_exec.push_back(e);
      step();
    end
    noise(1'b1);
    stall = 1'b0;
    e = '{inst: rdata, pc: m_pc, ret: m_ret, jbp: 1'b0, mis: m_mis};
    if (kind == K_HALT) begin
      halt = 1'b1;
    end else if (kind == K_JMP) begin
      halt = 1'b0; jb_taken = 1'b1; jb_target = tgt;
      e.jbp = 1'b1;
      m_pc = {tgt[15:1], 1'b0};
      m_mis = m_mis | tgt[0];
    end else begin
      halt = 1'b0; jb_taken = 1'b0;
      m_pc = m_pc + 16'd2;
    end
    q_exec.push_back(e);
    m_ret = m_ret + 16'd1;
    step();
    if (kind == K_HALT) begin
      repeat (r) begin noise(1'b1); resume = 1'b0; step(); end
      noise(1'b1);
      resume = 1'b1;
      q_halt.push_back(m_pc);
      m_pc = m_pc + 16'd2;
      step();
      resume = 1'b0;
    end
  endtask

  task automatic reset_checks();
    chk("rst_pc", pc, RST_PC);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_retire", retire_cnt, 16'h0000);
    chk("rst_outs", {11'd0, imem_req, inst_valid, jbp_enable, halted, misalign_err}, 16'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0; halt = 1'b0; resume = 1'b0; jb_taken = 1'b0;
    jb_target = 16'h0; imem_ack = 1'b0; imem_rdata = 16'h0;
    m_pc = RST_PC; m_ret = 16'h0; m_mis = 1'b0;
    repeat (2) step();
    reset_checks();
    rst_n = 1'b1;
    #1;
    chk("idle_req", {15'd0, imem_req}, 16'd0);
    step();
    chk("first_fetch_req", {15'd0, imem_req}, 16'd1);
    chk("first_fetch_addr", imem_addr, RST_PC);
    mon_en = 1'b1;

    run_instr(K_SEQ, 16'h0, 0, 0, 0, 16'hA5A5);
    run_instr(K_JMP, 16'h0010, 1, 0, 0, 16'h1111);
    run_instr(K_JMP, 16'h1234, 0, 1, 0, 16'h2222);
    run_instr(K_JMP, 16'h1235, 2, 0, 0, 16'h3333);
    run_instr(K_JMP, 16'hFFFE, 0, 0, 0, 16'h4444);
    run_instr(K_SEQ, 16'h0, 0, 0, 0, 16'h5555);
    run_instr(K_HALT, 16'h0, 0, 3, 2, 16'h6666);
    run_instr(K_SEQ, 16'h0, 0, 0, 0, 16'h7777);

    for (int i = 0; i < 150; i++) begin
      int k;
      int sel;
      sel = int'($urandom_range(0, 9));
      k = (sel == 0) ? K_HALT : (sel <= 3) ? K_JMP : K_SEQ;
      run_instr(k, 16'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), 16'($urandom));
    end

    run_instr(K_JMP, 16'h0040, 0, 0, 0, 16'h8888);
    noise(1'b0);
    step();
    chk("midfetch_pc", pc, 16'h0040);
    chk("midfetch_req", {15'd0, imem_req}, 16'd1);
    chk("mis_sticky", {15'd0, misalign_err}, {15'd0, m_mis});
    chk("queues_drained", 16'(q_fetch.size() + q_exec.size() + q_halt.size()), 16'd0);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks();
    step();
    rst_n = 1'b1;
    stall = 1'b0; halt = 1'b0; resume = 1'b0; jb_taken = 1'b0; imem_ack = 1'b0;
    step();
    chk("refetch_req", {15'd0, imem_req}, 16'd1);
    chk("refetch_addr", imem_addr, RST_PC);
    chk("refetch_retire", retire_cnt, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
